// File: rtl/gpc_bus_pkg.sv
// Shared definitions for the GPC CPU bus: bus widths, rw encoding and the
// memory responder's phase encoding.
package gpc_bus_pkg;

    localparam int unsigned GPC_ADDR_W = 16;
    localparam int unsigned GPC_DATA_W = 8;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } gpc_state_e;

endpackage

// File: rtl/gpc_ram_sp.sv
// Single-port byte RAM with synchronous read and write-first behaviour.
// Contents are never cleared; only the read register is reset.
module gpc_ram_sp
    import gpc_bus_pkg::*;
#(
    parameter int unsigned ADDR_W = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [GPC_DATA_W-1:0] wdata,
    output logic [GPC_DATA_W-1:0] rdata
);

    logic [GPC_DATA_W-1:0] mem [2**ADDR_W];

    // Array write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Registered read; a same-edge write is forwarded so reads see the new byte
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (we) begin
            rdata <= wdata;
        end else begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/gpc_bus_memory.sv
// Memory responder on the GPC CPU bus. After reset a LOAD phase fills the RAM
// from the byte-stream loader while the CPU is held; the block then answers
// bus reads and writes in RUN until the next reset.
// Optional feature macro: WRITE_PROTECT_EN (drops RUN writes below RO_LIMIT
// and pulses wp_err); when undefined all selected writes are taken.
module gpc_bus_memory
    import gpc_bus_pkg::*;
#(
    parameter int unsigned           ADDR_W   = 12,
    parameter logic [GPC_ADDR_W-1:0] BASE     = 16'h0000,
    parameter int unsigned           LOAD_LEN = 256,
    parameter logic [GPC_ADDR_W-1:0] RO_LIMIT = 16'h0100
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [GPC_ADDR_W-1:0] address,
    input  logic                  rw,
    inout  wire  [GPC_DATA_W-1:0] data,
    input  logic                  ld_valid,
    input  logic [GPC_DATA_W-1:0] ld_data,
    output logic                  ld_ready,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  wp_err
);

`ifdef WRITE_PROTECT_EN
    localparam bit WP_EN = 1'b1;
`else
    localparam bit WP_EN = 1'b0;
`endif

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(LOAD_LEN - 1);

    gpc_state_e            state;
    logic [ADDR_W-1:0]     load_ptr;
    logic                  sel_q;
    logic [GPC_DATA_W-1:0] rd_q;

    logic                  sel;
    logic [ADDR_W-1:0]     off;
    logic                  in_ro;
    logic                  blocked;
    logic                  ld_accept;
    logic                  run_wr;
    logic                  ram_we;
    logic [ADDR_W-1:0]     ram_addr;
    logic [GPC_DATA_W-1:0] ram_wdata;
    logic                  drive;

    assign sel   = (address[GPC_ADDR_W-1:ADDR_W] == BASE[GPC_ADDR_W-1:ADDR_W]);
    assign off   = address[ADDR_W-1:0];
    assign in_ro = (GPC_ADDR_W'(off) < RO_LIMIT);

    assign blocked   = WP_EN & in_ro;
    assign ld_accept = (state == ST_LOAD) && ld_valid && ld_ready;
    assign run_wr    = (state == ST_RUN) && (rw == RW_WRITE) && sel;

    // Write port belongs to the loader in LOAD and to the bus in RUN
    assign ram_we    = !rst && (ld_accept || (run_wr && !blocked));
    assign ram_addr  = (state == ST_LOAD) ? load_ptr : off;
    assign ram_wdata = (state == ST_LOAD) ? ld_data : data;

    // Drive only for a read whose address was selected in RUN at the last edge;
    // rw high releases the bus in the same cycle to avoid a turnaround fight
    assign drive = !rst && sel_q && (rw == RW_READ);
    assign data  = drive ? rd_q : {GPC_DATA_W{1'bz}};

    gpc_ram_sp #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (rd_q)
    );

    // LOAD/RUN sequencing with registered handshake and status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_LOAD;
            load_ptr  <= '0;
            ld_ready  <= 1'b0;
            cpu_hold  <= 1'b1;
            load_done <= 1'b0;
            sel_q     <= 1'b0;
        end else begin
            load_done <= 1'b0;
            sel_q     <= 1'b0;
            unique case (state)
                ST_LOAD: begin
                    ld_ready <= 1'b1;
                    cpu_hold <= 1'b1;
                    if (ld_accept) begin
                        load_ptr <= load_ptr + 1'b1;
                        if (load_ptr == LAST_PTR) begin
                            state     <= ST_RUN;
                            ld_ready  <= 1'b0;
                            cpu_hold  <= 1'b0;
                            load_done <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    ld_ready <= 1'b0;
                    cpu_hold <= 1'b0;
                    sel_q    <= sel;
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

`ifdef WRITE_PROTECT_EN
    // One pulse per blocked RUN write cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            wp_err <= 1'b0;
        end else begin
            wp_err <= run_wr && blocked;
        end
    end
`else
    assign wp_err = 1'b0;
`endif

endmodule

// File: tb/tb_gpc_bus_memory.sv
// Randomized self-checking bench for gpc_bus_memory against a byte-array
// reference model of the LOAD and RUN behaviour. The data bus has a pull-up,
// so an undriven (Z) bus reads back as 8'hFF.
module tb_gpc_bus_memory;

    localparam int unsigned ADDR_W   = 12;
    localparam int unsigned LOAD_LEN = 4;
    localparam logic [15:0] BASE     = 16'h0000;
    localparam logic [15:0] RO_LIMIT = 16'h0100;
`ifdef WRITE_PROTECT_EN
    localparam bit WP = 1'b1;
`else
    localparam bit WP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] address = '0;
    logic        rw = 1'b0;
    logic        ld_valid = 1'b0;
    logic [7:0]  ld_data = '0;
    logic        ld_ready, cpu_hold, load_done, wp_err;
    logic [7:0]  drv = '0;
    logic        drive = 1'b0;
    tri1  [7:0]  data;

    assign data = drive ? drv : 8'hzz;

    always #5 clk = ~clk;

    gpc_bus_memory #(
        .ADDR_W   (ADDR_W),
        .BASE     (BASE),
        .LOAD_LEN (LOAD_LEN),
        .RO_LIMIT (RO_LIMIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .address   (address),
        .rw        (rw),
        .data      (data),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_ready  (ld_ready),
        .cpu_hold  (cpu_hold),
        .load_done (load_done),
        .wp_err    (wp_err)
    );

    // Reference model
    logic [7:0] mem_m [4096];
    bit         known [4096];
    bit         m_loading = 1'b1;
    int         m_count = 0;
    bit         m_ready = 1'b0;
    bit         m_hold = 1'b1;
    bit         m_done = 1'b0;
    bit         m_wp = 1'b0;
    bit         m_sel_prev = 1'b0;
    logic [7:0] m_rd = '0;
    bit         m_rd_known = 1'b0;

    int checks = 0;
    int failures = 0;
    int done_seen = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One bus cycle: apply inputs, check the bus, advance model and DUT one edge
    task automatic cyc(input bit r, input logic [15:0] a, input bit w, input bit tdrv,
                       input logic [7:0] d, input bit lv, input logic [7:0] ld);
        bit         sel;
        int         off;
        bit         prot;
        logic [7:0] bus_val;
        rst = r; address = a; rw = w; drive = w && tdrv; drv = d;
        ld_valid = lv; ld_data = ld;
        #1;
        bus_val = (w && tdrv) ? d : 8'hFF;
        if (!r && !w && m_sel_prev) begin
            if (m_rd_known) check("rd_data", 16'(data), 16'(m_rd));
        end else begin
            check("bus_idle", 16'(data), 16'(bus_val));
        end

        if (r) begin
            m_loading = 1'b1; m_count = 0; m_ready = 1'b0; m_hold = 1'b1;
            m_done = 1'b0; m_wp = 1'b0; m_sel_prev = 1'b0;
        end else if (m_loading) begin
            m_done = 1'b0; m_wp = 1'b0; m_sel_prev = 1'b0;
            if (lv && m_ready) begin
                mem_m[m_count] = ld;
                known[m_count] = 1'b1;
                m_count++;
            end
            if (m_count == int'(LOAD_LEN)) begin
                m_loading = 1'b0; m_ready = 1'b0; m_hold = 1'b0; m_done = 1'b1;
            end else begin
                m_ready = 1'b1;
            end
        end else begin
            sel  = (a[15:12] == BASE[15:12]);
            off  = int'(a) % 4096;
            prot = WP && (off < int'(RO_LIMIT));
            m_done = 1'b0; m_ready = 1'b0; m_hold = 1'b0;
            m_wp = w && sel && prot;
            if (w && sel && !prot) begin
                mem_m[off] = bus_val;
                known[off] = 1'b1;
            end
            m_rd = mem_m[off];
            m_rd_known = known[off];
            m_sel_prev = sel;
        end

        @(posedge clk);
        #1;
        if (load_done) done_seen++;
        check("ld_ready", 16'(ld_ready), 16'(m_ready));
        check("cpu_hold", 16'(cpu_hold), 16'(m_hold));
        check("load_done", 16'(load_done), 16'(m_done));
        check("wp_err", 16'(wp_err), 16'(m_wp));
    endtask

    // Stream loader bytes with random valid gaps until the model has taken n
    task automatic load_stream(input int n, input bit fixed, input logic [7:0] first);
        int         guard = 0;
        logic [7:0] b;
        while (m_count < n && m_loading && guard < 200) begin
            b = fixed ? 8'(first + 8'(m_count)) : 8'($urandom);
            cyc(1'b0, 16'($urandom), 1'b0, 1'b0, 8'h00, ($urandom_range(0, 3) != 0), b);
            guard++;
        end
        if (guard >= 200) check("load_timeout", 16'(guard), 16'(0));
    endtask

    task automatic read2(input logic [15:0] a);
        cyc(1'b0, a, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        cyc(1'b0, a, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    task automatic write1(input logic [15:0] a, input logic [7:0] d);
        cyc(1'b0, a, 1'b1, 1'b1, d, 1'b0, 8'h00);
    endtask

    initial begin
        logic [15:0] bases [5];
        bases[0] = 16'h0000; bases[1] = 16'h00F8; bases[2] = 16'h0100;
        bases[3] = 16'h2000; bases[4] = 16'hF000;

        // Reset, then load A0..A3
        cyc(1'b1, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        load_stream(int'(LOAD_LEN), 1'b1, 8'hA0);
        check("load_done_count", 16'(done_seen), 16'(1));

        // Read after load; rw high with bus floating must not be driven by the DUT
        read2(16'h0002);
        cyc(1'b0, 16'h0002, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        read2(16'h0002);

        // Two-cycle write then readback
        write1(16'h0010, 8'h5C);
        write1(16'h0010, 8'h5C);
        read2(16'h0010);

        // Unselected window: no drive, no write
        write1(16'h2000, 8'h77);
        read2(16'h2000);
        read2(16'h0000);

        // Protected range (only blocks under the write-protect build)
        write1(16'h0001, 8'hFF);
        read2(16'h0001);
        write1(16'h0100, 8'h66);
        read2(16'h0100);

        // Randomized RUN traffic
        for (int i = 0; i < 600; i++) begin
            cyc(1'b0, bases[$urandom_range(0, 4)] + 16'($urandom_range(0, 7)),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) != 0),
                8'($urandom), 1'($urandom), 8'($urandom));
        end

        // Mid-load reset, then a fresh image
        cyc(1'b1, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        load_stream(2, 1'b0, 8'h00);
        cyc(1'b1, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        done_seen = 0;
        load_stream(int'(LOAD_LEN), 1'b0, 8'h00);
        cyc(1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00);
        check("reload_done_count", 16'(done_seen), 16'(1));
        for (int i = 0; i < 4; i++) read2(16'(i));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
